sa_read_capture: RTL

// - Read-path stage directly downstream of the column sense amplifiers in the mixed-signal SRAM macro.
// - Sequences one read: bitline precharge, wordline/bitline develop, sense enable.
// - Thresholds the per-column real-valued sense-amp outputs against VTH and latches them as a digital word.
// - Presents the word to the digital read port with a valid/ready handshake.

---
 rtl/sram_ms_pkg.sv | 17 +
 rtl/sa_slicer.sv | 19 +
 rtl/sa_read_capture.sv | 104 ++++++++++
 3 files changed

// File: rtl/sram_ms_pkg.sv
// Shared definitions for the mixed-signal SRAM macro read path:
// supply/threshold voltages and the read sequencer state encoding.
package sram_ms_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [2:0] {
    IDLE,
    PRECH,
    DEVELOP,
    SENSE,
    HOLD
  } rd_state_e;

endpackage

// File: rtl/sa_slicer.sv
// Per-column threshold array: turns real-valued sense-amp outputs into bits.
// A column at exactly VTH resolves to 1.
module sa_slicer
  import sram_ms_pkg::*;
#(
  parameter int COLS = 16
) (
  input  real              preout [COLS],
  output logic [COLS-1:0]  bits
);

  always_comb begin
    bits = '0;
    for (int i = 0; i < COLS; i++) begin
      bits[i] = (preout[i] >= VTH);
    end
  end

endmodule

// File: rtl/sa_read_capture.sv
// Read-path stage behind the column sense amps: sequences precharge, develop
// and sense, captures the thresholded word and offers it on a valid/ready port.
module sa_read_capture
  import sram_ms_pkg::*;
#(
  parameter int COLS          = 16,
  parameter int PRE_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  input  real              preout [COLS],
  input  logic             dout_ready,
  output logic             pre_en,
  output logic             wl_en,
  output logic             sae,
  output logic             busy,
  output logic [COLS-1:0]  dout,
  output logic             dout_valid
);

  localparam int MAX_CYCLES = (PRE_CYCLES > SETTLE_CYCLES) ? PRE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] PRE_LOAD    = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  if (PRE_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_param_check
    $error("sa_read_capture: PRE_CYCLES and SETTLE_CYCLES must both be >= 1");
  end

  rd_state_e        state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [COLS-1:0]  sliced;

  sa_slicer #(
    .COLS (COLS)
  ) u_slicer (
    .preout (preout),
    .bits   (sliced)
  );

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (rd_req) begin
          next_state = PRECH;
          next_cnt   = PRE_LOAD;
        end
      end
      PRECH: begin
        if (cnt == '0) begin
          next_state = DEVELOP;
          next_cnt   = SETTLE_LOAD;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      DEVELOP: begin
        if (cnt == '0) begin
          next_state = SENSE;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      SENSE: next_state = HOLD;
      HOLD: begin
        if (dout_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Enables are decoded from next_state so each is a clean flop output
  // that is high for exactly the cycles the FSM spends in its state(s).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pre_en     <= 1'b0;
      wl_en      <= 1'b0;
      sae        <= 1'b0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      pre_en     <= (next_state == PRECH);
      wl_en      <= (next_state == DEVELOP) || (next_state == SENSE);
      sae        <= (next_state == SENSE);
      busy       <= (next_state != IDLE);
      dout_valid <= (next_state == HOLD);
      if (state == SENSE) begin
        dout <= sliced;
      end
    end
  end

endmodule
